// File: rtl/mem_arbiter_if.sv
// Bus bundle between the miniRV fetch/load-store requesters, the shared-memory arbiter and memory.
// The arbiter uses the slave modport; the environment (core + memory) uses the master modport.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch (I) and load/store (D) requesters onto one single-port memory,
// with starvation protection for I and a fixed-latency pipeline that routes read data back.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 3
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {SEL_NONE, SEL_I, SEL_D} sel_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  sel_t              sel;
  logic [3:0]        cnt;
  logic [3:0]        cnt_next;
  logic              i_gnt;
  logic              d_gnt;
  logic              rd_accept;
  logic              rd_owner;
  logic [RD_LAT-1:0] pipe_valid;
  logic [RD_LAT-1:0] pipe_owner;

  // D wins contention until I has lost STARVE_MAX times in a row.
  always_comb begin
    sel = SEL_NONE;
    if (bus.i_req && bus.d_req) begin
      sel = (cnt >= STARVE_LIM) ? SEL_I : SEL_D;
    end else if (bus.i_req) begin
      sel = SEL_I;
    end else if (bus.d_req) begin
      sel = SEL_D;
    end
  end

  // Grants are masked by reset so nothing is accepted while rst is held low.
  assign i_gnt     = rst && (sel == SEL_I) && bus.mem_ready;
  assign d_gnt     = rst && (sel == SEL_D) && bus.mem_ready;
  assign rd_accept = i_gnt | (d_gnt & ~bus.d_we);
  assign rd_owner  = d_gnt;

  always_comb begin
    cnt_next = cnt;
    if (!bus.i_req || i_gnt) begin
      cnt_next = '0;
    end else if (d_gnt && (cnt < STARVE_LIM)) begin
      cnt_next = cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  // Owner bit: 0 = fetch, 1 = load. Shifts every cycle; memory has no response backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_valid <= '0;
      pipe_owner <= '0;
    end else begin
      pipe_valid[0] <= rd_accept;
      pipe_owner[0] <= rd_owner;
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_owner[k] <= pipe_owner[k-1];
      end
    end
  end

  always_comb begin
    bus.i_gnt     = i_gnt;
    bus.d_gnt     = d_gnt;
    bus.i_rvalid  = pipe_valid[RD_LAT-1] & ~pipe_owner[RD_LAT-1];
    bus.d_rvalid  = pipe_valid[RD_LAT-1] &  pipe_owner[RD_LAT-1];
    bus.i_rdata   = '0;
    bus.d_rdata   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (rst) begin
      bus.i_rdata = bus.mem_rdata;
      bus.d_rdata = bus.mem_rdata;
      bus.mem_req = bus.i_req | bus.d_req;
      case (sel)
        SEL_I: begin
          bus.mem_addr = bus.i_addr;
        end
        SEL_D: begin
          bus.mem_addr  = bus.d_addr;
          bus.mem_we    = bus.d_we;
          bus.mem_wdata = bus.d_wdata;
        end
        default: begin
          bus.mem_addr = '0;
        end
      endcase
    end
  end
endmodule
